test_regmaster8: RTL and testbench
==================================

# test_regmaster8

Avalon-MM master that exercises an 8-bit read/write test register at the other end of the bus. On a start pulse it checks the register's reset value, then runs a write/read-back loop over a pattern sequence and counts mismatches and timeouts. Status goes out on a conduit. It sits in the Qsys system as a bring-up/self-test initiator alongside the register slaves it targets.

## Interface
- ADDR_W, 4: byte address width of avm_TestReg_address.
- TARGET_ADDR, 0: address of the register under test.
- EXPECT_RST, 8'h5A: value the first read must return.
- SEED, 8'h01: first write pattern.
- STEP, 8'h25: pattern increment per iteration, mod 256.
- ITERATIONS, 16: write/read pairs per run, 1..255.
- TIMEOUT, 64: max cycles waiting on readdatavalid per read, ≥2.
- rsi_MRST_reset  in  1  reset; asynchronous, active-high.
- csi_MCLK_clk  in  1  clock; all logic on rising edge.
- avm_TestReg_address  out  ADDR_W  always TARGET_ADDR.
- avm_TestReg_read  out  1  read request.
- avm_TestReg_write  out  1  write request.
- avm_TestReg_writedata  out  8  write data.
- avm_TestReg_readdata  in  8  read data, valid with readdatavalid.
- avm_TestReg_waitrequest  in  1  slave stall.
- avm_TestReg_readdatavalid  in  1  read data strobe.
- coe_start  in  1  level; sampled only in IDLE.
- coe_busy  out  1  run in progress.
- coe_done  out  1  run finished; held until next start.
- coe_pass  out  1  done with zero errors.
- coe_errcnt  out  8  mismatches + timeouts, saturating at 255.
- coe_lastbad  out  8  readdata of the most recent mismatch.

## Operation
- Reset: state IDLE; read=write=0, writedata=0, busy=done=pass=0, errcnt=0, lastbad=0, iteration counter=0, pattern=SEED.
- States: IDLE, RD_RST, WAIT_RST, WR, RD, WAIT_RD, DONE.
- IDLE: if coe_start=1 → RD_RST; clear errcnt, lastbad, done, pass; pattern=SEED; iter=0; busy=1.
- RD_RST/RD: assert read; hold read and address while waitrequest=1. The request is accepted in the cycle read=1 and waitrequest=0. Then go to WAIT_RST/WAIT_RD and drop read the next cycle.
- readdatavalid in the acceptance cycle itself (zero latency) is legal. Capture it there and skip the wait state (go straight to the compare result).
- WAIT_*: count cycles from acceptance. On readdatavalid, compare readdata with the expected value: EXPECT_RST for the reset read, pattern for a loop read.
  - Mismatch: errcnt+1 (saturating); lastbad=readdata.
  - Timeout (TIMEOUT cycles without readdatavalid): errcnt+1; lastbad unchanged.
- After the reset-read result → WR.
- WR: assert write with writedata=pattern; hold while waitrequest=1; on acceptance → RD.
- After a loop-read result: pattern += STEP (8-bit wrap) and iter += 1. If iter == ITERATIONS → DONE, else → WR.
- DONE: busy=0, done=1, pass=(errcnt==0). Stay until coe_start=1, which starts a new run (same as IDLE with start).
- read and write are never asserted together. The master never issues a new request while a read response is outstanding.
- readdatavalid outside WAIT_*, or in a cycle where no acceptance occurred, is ignored.
- Reset mid-run aborts immediately to reset values. Outstanding responses arriving after reset are ignored.

## Timing
- Registered outputs; no combinational path from any input to any output.
- Zero-wait slave, readdatavalid one cycle after acceptance:
  - run = 1 (RD_RST) + 1 (WAIT) + ITERATIONS×(1 WR + 1 RD + 1 WAIT) cycles, then DONE.
  - ITERATIONS=16 gives 50 cycles from start-sample to done=1.
- done, pass and errcnt are final in the same cycle done rises.
- Each waitrequest cycle stretches the affected request by one cycle.
- A timeout costs exactly TIMEOUT cycles after acceptance.

## Test plan
- Zero-wait slave model with reset value 8'h5A, defaults, start pulse → writes 01,26,4B,…; done=1 at cycle 50; pass=1; errcnt=0.
- Slave model resets to 8'h00 → errcnt=1, lastbad=00, pass=0. The 16 loop compares still pass.
- Random waitrequest (~50%) on reads and writes → address/data/read/write stable while stalled; no duplicate acceptances; pass=1.
- Slave drops readdatavalid on iteration 3 → that read times out after 64 cycles; errcnt=1; lastbad unchanged; the run continues to done.
- Slave with stuck bit 0 → every pattern with bit0=0 mismatches; errcnt equals the count of such patterns; lastbad is the final bad read. Separately, force >255 errors (ITERATIONS=255, dead slave): errcnt saturates at 255.
- Assert reset during WAIT_RD with a response pending → all outputs return to reset values within the reset assertion. The late readdatavalid is ignored. A new start runs cleanly to pass=1.

Source files
------------

// File: rtl/test_regmaster8_if.sv
// Avalon-MM bus between the register self-test master and the 8-bit test register slave.
interface test_regmaster8_if #(
   parameter int ADDR_W = 4
) ();
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [7:0]        writedata;
   logic [7:0]        readdata;
   logic              waitrequest;
   logic              readdatavalid;

   modport master (
      output address, read, write, writedata,
      input  readdata, waitrequest, readdatavalid
   );

   modport slave (
      input  address, read, write, writedata,
      output readdata, waitrequest, readdatavalid
   );
endinterface

// File: rtl/test_regmaster8.sv
// Avalon-MM self-test master: checks a test register's reset value, then runs a
// write/read-back pattern loop, counting mismatches and read timeouts.
module test_regmaster8 #(
   parameter int         ADDR_W      = 4,
   parameter int         TARGET_ADDR = 0,
   parameter logic [7:0] EXPECT_RST  = 8'h5A,
   parameter logic [7:0] SEED        = 8'h01,
   parameter logic [7:0] STEP        = 8'h25,
   parameter int         ITERATIONS  = 16,
   parameter int         TIMEOUT     = 64
) (
   input  logic                     csi_MCLK_clk,
   input  logic                     rsi_MRST_reset,
   test_regmaster8_if.master        avm_TestReg,
   input  logic                     coe_start,
   output logic                     coe_busy,
   output logic                     coe_done,
   output logic                     coe_pass,
   output logic [7:0]               coe_errcnt,
   output logic [7:0]               coe_lastbad
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_RST, S_WAIT_RST, S_WR, S_RD, S_WAIT_RD, S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic             read_q, read_d, write_q, write_d;
   logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [7:0]       wdata_q, wdata_d, errcnt_q, errcnt_d, lastbad_q, lastbad_d;
   logic [7:0]       pattern_q, pattern_d, iter_q, iter_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       start_ok, rd_acc, wr_acc, in_wait, got, tmo, res, rst_phase, bad, last;
   logic [7:0] exp_val, next_pat;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign start_ok  = coe_start && (state_q == S_IDLE || state_q == S_DONE);
   assign rd_acc    = (state_q == S_RD_RST || state_q == S_RD) && !avm_TestReg.waitrequest;
   assign wr_acc    = (state_q == S_WR) && !avm_TestReg.waitrequest;
   assign in_wait   = (state_q == S_WAIT_RST || state_q == S_WAIT_RD);
   // A zero-latency response in the acceptance cycle counts just like one in a wait state.
   assign got       = (rd_acc || in_wait) && avm_TestReg.readdatavalid;
   assign tmo       = in_wait && !avm_TestReg.readdatavalid && (cnt_q == CNT_W'(TIMEOUT));
   assign res       = got || tmo;
   assign rst_phase = (state_q == S_RD_RST || state_q == S_WAIT_RST);
   assign exp_val   = rst_phase ? EXPECT_RST : pattern_q;
   assign bad       = got && (avm_TestReg.readdata != exp_val);
   assign last      = ({1'b0, iter_q} + 9'd1) == 9'(ITERATIONS);
   assign next_pat  = pattern_q + STEP;

   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         state_q   <= S_IDLE;
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         wdata_q   <= 8'h00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         errcnt_q  <= 8'h00;
         lastbad_q <= 8'h00;
         pattern_q <= SEED;
         iter_q    <= 8'h00;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         read_q    <= read_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         errcnt_q  <= errcnt_d;
         lastbad_q <= lastbad_d;
         pattern_q <= pattern_d;
         iter_q    <= iter_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (coe_start) state_d = S_RD_RST;
         S_RD_RST:       if (rd_acc) state_d = got ? S_WR : S_WAIT_RST;
         S_WAIT_RST:     if (res) state_d = S_WR;
         S_WR:           if (wr_acc) state_d = S_RD;
         S_RD:           if (rd_acc) state_d = got ? (last ? S_DONE : S_WR) : S_WAIT_RD;
         S_WAIT_RD:      if (res) state_d = last ? S_DONE : S_WR;
         default:        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      read_d    = read_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      busy_d    = busy_q;
      done_d    = done_q;
      pass_d    = pass_q;
      errcnt_d  = errcnt_q;
      lastbad_d = lastbad_q;
      pattern_d = pattern_q;
      iter_d    = iter_q;
      cnt_d     = cnt_q;

      if (start_ok) begin
         errcnt_d  = 8'h00;
         lastbad_d = 8'h00;
         done_d    = 1'b0;
         pass_d    = 1'b0;
         pattern_d = SEED;
         iter_d    = 8'h00;
         busy_d    = 1'b1;
         read_d    = 1'b1;
      end

      if (rd_acc) begin
         read_d = 1'b0;
         cnt_d  = CNT_W'(1);
      end else if (in_wait && !res) begin
         cnt_d = cnt_q + 1'b1;
      end

      if (wr_acc) begin
         write_d = 1'b0;
         read_d  = 1'b1;
      end

      if (res) begin
         if (bad || tmo) errcnt_d = sat_inc(errcnt_q);
         if (bad) lastbad_d = avm_TestReg.readdata;
         if (rst_phase) begin
            write_d = 1'b1;
            wdata_d = pattern_q;
         end else begin
            pattern_d = next_pat;
            iter_d    = iter_q + 8'd1;
            // errcnt_d already includes this result, so pass is final as done rises.
            if (last) begin
               busy_d = 1'b0;
               done_d = 1'b1;
               pass_d = (errcnt_d == 8'h00);
            end else begin
               write_d = 1'b1;
               wdata_d = next_pat;
            end
         end
      end
   end

   assign avm_TestReg.address   = ADDR_W'(TARGET_ADDR);
   assign avm_TestReg.read      = read_q;
   assign avm_TestReg.write     = write_q;
   assign avm_TestReg.writedata = wdata_q;
   assign coe_busy              = busy_q;
   assign coe_done              = done_q;
   assign coe_pass              = pass_q;
   assign coe_errcnt            = errcnt_q;
   assign coe_lastbad           = lastbad_q;
endmodule

// File: tb/tb_test_regmaster8.sv
// Bench for test_regmaster8: behavioural Avalon slave plus a pattern-level model of a run.
module tb_test_regmaster8;
   logic       clk = 1'b0;
   logic       rst;
   logic       start, start2;
   logic       busy, done, pass, busy2, done2, pass2;
   logic [7:0] errcnt, lastbad, errcnt2, lastbad2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   test_regmaster8_if #(.ADDR_W(4)) bus ();
   test_regmaster8_if #(.ADDR_W(4)) bus2 ();

   test_regmaster8 u_dut (
      .csi_MCLK_clk(clk), .rsi_MRST_reset(rst), .avm_TestReg(bus),
      .coe_start(start), .coe_busy(busy), .coe_done(done), .coe_pass(pass),
      .coe_errcnt(errcnt), .coe_lastbad(lastbad)
   );

   test_regmaster8 #(.ITERATIONS(255), .TIMEOUT(4)) u_sat (
      .csi_MCLK_clk(clk), .rsi_MRST_reset(rst), .avm_TestReg(bus2),
      .coe_start(start2), .coe_busy(busy2), .coe_done(done2), .coe_pass(pass2),
      .coe_errcnt(errcnt2), .coe_lastbad(lastbad2)
   );

   // slave configuration, written only by the main sequence
   int         epoch     = 0;
   logic [7:0] cfg_rst   = 8'h5A;
   bit         cfg_wait  = 1'b0;
   bit         cfg_stuck = 1'b0;
   int         cfg_lat   = 1;
   int         cfg_drop  = -1;

   // slave state, written only by the slave process
   typedef struct { int due; logic [7:0] data; } pend_t;
   pend_t      pend[$];
   logic [7:0] wr_log[$];
   logic [7:0] sreg;
   int         cyc = 0, seen_epoch = -1;
   int         rd_cnt = 0, wr_cnt = 0, rdv_cnt = 0, viol = 0;
   bit         stall_rd = 1'b0, stall_wr = 1'b0;
   logic [3:0] last_addr;
   logic [7:0] last_wd;

   initial begin : slave
      bus.waitrequest = 1'b0; bus.readdatavalid = 1'b0; bus.readdata = 8'h00;
      sreg = 8'h5A; last_addr = 4'h0; last_wd = 8'h00;
      forever begin
         @(negedge clk);
         cyc++;
         if (epoch != seen_epoch) begin
            seen_epoch = epoch; sreg = cfg_rst;
            rd_cnt = 0; wr_cnt = 0; rdv_cnt = 0; viol = 0;
            wr_log.delete(); pend.delete();
            stall_rd = 1'b0; stall_wr = 1'b0;
         end
         if (stall_rd && (!bus.read || bus.address != last_addr)) viol++;
         if (stall_wr && (!bus.write || bus.writedata != last_wd)) viol++;
         if (bus.read && bus.write) viol++;
         if ((bus.read || bus.write) && bus.address != 4'h0) viol++;
         bus.waitrequest   = cfg_wait ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.readdatavalid = 1'b0;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            bus.readdatavalid = 1'b1; bus.readdata = pend[0].data;
            rdv_cnt++; void'(pend.pop_front());
         end
         if (bus.read && !bus.waitrequest && !rst) begin
            if (rd_cnt != cfg_drop) begin
               if (cfg_lat == 0) begin
                  bus.readdatavalid = 1'b1; bus.readdata = sreg; rdv_cnt++;
               end else pend.push_back('{cyc + cfg_lat, sreg});
            end
            rd_cnt++;
         end
         if (bus.write && !bus.waitrequest && !rst) begin
            sreg = cfg_stuck ? (bus.writedata | 8'h01) : bus.writedata;
            wr_log.push_back(bus.writedata);
            wr_cnt++;
         end
         stall_rd = bus.read && bus.waitrequest;
         stall_wr = bus.write && bus.waitrequest;
         last_addr = bus.address; last_wd = bus.writedata;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pat(input int i);
      return 8'((1 + 37 * i) % 256);
   endfunction

   // Expected error count / last bad value of a 16-iteration run.
   task automatic model(input logic [7:0] rv, input bit stk, input int drop,
                        output logic [7:0] e_err, output logic [7:0] e_lb);
      int err = 0;
      logic [7:0] st;
      e_lb = 8'h00;
      if (rv != 8'h5A) begin err++; e_lb = rv; end
      for (int i = 0; i < 16; i++) begin
         st = stk ? (pat(i) | 8'h01) : pat(i);
         if (i + 1 == drop) err++;
         else if (st != pat(i)) begin err++; e_lb = st; end
      end
      e_err = (err > 255) ? 8'hFF : 8'(err);
   endtask

   task automatic prep(input logic [7:0] rv, input bit w, input bit stk, input int lat, input int drop);
      @(negedge clk); #2;
      cfg_rst = rv; cfg_wait = w; cfg_stuck = stk; cfg_lat = lat; cfg_drop = drop;
      epoch++;
   endtask

   task automatic run(input string tag, input int maxc, output int cycles);
      start = 1'b1;
      @(negedge clk); #2;
      start = 1'b0;
      cycles = 0;
      check({tag, "_busy_run"}, busy, 1);
      while (!done && cycles < maxc) begin
         @(negedge clk); #2;
         cycles++;
      end
      check({tag, "_done"}, done, 1);
   endtask

   task automatic post(input string tag, input int cycles, input int e_cyc,
                       input logic [7:0] e_err, input logic [7:0] e_lb, input logic e_pass);
      int bad = 0;
      if (e_cyc >= 0) check({tag, "_cycles"}, cycles, e_cyc);
      check({tag, "_errcnt"}, errcnt, e_err);
      check({tag, "_lastbad"}, lastbad, e_lb);
      check({tag, "_pass"}, pass, e_pass);
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_bus_viol"}, viol, 0);
      check({tag, "_reads"}, rd_cnt, 17);
      check({tag, "_writes"}, wr_cnt, 16);
      for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] !== pat(i)) bad++;
      check({tag, "_wrseq"}, bad, 0);
   endtask

   initial begin : main
      int cycles, waited;
      logic [7:0] e_err, e_lb;
      rst = 1'b1; start = 1'b0; start2 = 1'b0;
      bus2.waitrequest = 1'b0; bus2.readdatavalid = 1'b0; bus2.readdata = 8'h00;
      repeat (3) @(negedge clk);
      #2;
      check("rst_read", bus.read, 0);
      check("rst_write", bus.write, 0);
      check("rst_wdata", bus.writedata, 0);
      check("rst_addr", bus.address, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_errcnt", errcnt, 0);
      check("rst_lastbad", lastbad, 0);
      check("rst_sat_wdata", bus2.writedata, 0);
      rst = 1'b0;

      // good slave, default timing
      prep(8'h5A, 0, 0, 1, -1);
      run("dflt", 200, cycles);
      model(8'h5A, 0, -1, e_err, e_lb);
      post("dflt", cycles, 50, e_err, e_lb, 1);
      repeat (3) @(negedge clk);
      #2 check("dflt_done_held", done, 1);

      // slave reset value wrong
      prep(8'h00, 0, 0, 1, -1);
      run("rst00", 200, cycles);
      model(8'h00, 0, -1, e_err, e_lb);
      post("rst00", cycles, 50, e_err, e_lb, 0);

      // random waitrequest on every request
      prep(8'h5A, 1, 0, 1, -1);
      run("wait", 1000, cycles);
      model(8'h5A, 0, -1, e_err, e_lb);
      post("wait", cycles, -1, e_err, e_lb, 1);

      // response to loop iteration 3 dropped
      prep(8'h5A, 0, 0, 1, 4);
      run("drop", 400, cycles);
      model(8'h5A, 0, 4, e_err, e_lb);
      post("drop", cycles, 50 + 63, e_err, e_lb, 0);

      // stored bit 0 stuck at one
      prep(8'h5A, 0, 1, 1, -1);
      run("stuck", 200, cycles);
      model(8'h5A, 1, -1, e_err, e_lb);
      post("stuck", cycles, 50, e_err, e_lb, 0);

      // zero-latency responses
      prep(8'h5A, 0, 0, 0, -1);
      run("zlat", 200, cycles);
      model(8'h5A, 0, -1, e_err, e_lb);
      post("zlat", cycles, 33, e_err, e_lb, 1);

      // reset while a loop read response is outstanding
      prep(8'h5A, 0, 0, 5, -1);
      start = 1'b1;
      @(negedge clk); #2 start = 1'b0;
      waited = 0;
      while (rd_cnt < 3 && waited < 300) begin
         @(negedge clk); #2;
         waited++;
      end
      check("mr_reach_rd", rd_cnt, 3);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      check("mr_busy", busy, 0);
      check("mr_read", bus.read, 0);
      check("mr_write", bus.write, 0);
      check("mr_wdata", bus.writedata, 0);
      check("mr_done", done, 0);
      check("mr_errcnt", errcnt, 0);
      @(negedge clk); #2 rst = 1'b0;
      repeat (6) @(negedge clk);
      #2;
      check("mr_late_delivered", rdv_cnt, 3);
      check("mr_idle_busy", busy, 0);
      check("mr_idle_done", done, 0);
      check("mr_idle_errcnt", errcnt, 0);
      check("mr_idle_lastbad", lastbad, 0);
      check("mr_no_new_req", rd_cnt + wr_cnt, 5);
      prep(8'h5A, 0, 0, 1, -1);
      run("mr_rerun", 200, cycles);
      model(8'h5A, 0, -1, e_err, e_lb);
      post("mr_rerun", cycles, 50, e_err, e_lb, 1);

      // 255 iterations against a slave that never answers
      @(negedge clk); #2 start2 = 1'b1;
      @(negedge clk); #2 start2 = 1'b0;
      check("sat_busy", busy2, 1);
      check("sat_rd_wr_excl", bus2.read & bus2.write, 0);
      check("sat_addr", bus2.address, 0);
      waited = 0;
      while (!done2 && waited < 3000) begin
         @(negedge clk); #2;
         waited++;
      end
      check("sat_done", done2, 1);
      check("sat_errcnt", errcnt2, 8'hFF);
      check("sat_pass", pass2, 0);
      check("sat_lastbad", lastbad2, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
